// File: rtl/alu_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle ALU control sequencer: opcodes, instruction
// field positions, FSM state encoding and small helpers.
package alu_ctrl_fsm_pkg;

  localparam int unsigned InstrW = 16;
  localparam int unsigned FieldW = 4;

  localparam int unsigned OpcodeLsb = 12;
  localparam int unsigned RdLsb     = 8;
  localparam int unsigned RsLsb     = 4;
  localparam int unsigned RtLsb     = 0;
  // jmp targets come from the low 12 instruction bits
  localparam int unsigned JmpW      = 12;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_HALT = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_ADDI = 4'b1010;
  localparam logic [3:0] OP_SUBI = 4'b1011;
  localparam logic [3:0] OP_BZ   = 4'b1100;
  localparam logic [3:0] OP_JMP  = 4'b1111;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StAwait,
    StWb,
    StMem,
    StHalt
  } state_e;

  function automatic logic [InstrW-1:0] sext_imm4(input logic [FieldW-1:0] imm);
    return {{(InstrW - FieldW){imm[FieldW-1]}}, imm};
  endfunction

endpackage

// File: rtl/alu_ctrl_fsm_instr_decode.sv
// Combinational opcode classifier feeding the sequencer's DECODE/EXEC/AWAIT decisions.
module alu_ctrl_fsm_instr_decode
  import alu_ctrl_fsm_pkg::*;
(
  input  logic [3:0] opcode_i,
  output logic       is_arith_o,
  output logic       uses_imm_o,
  output logic       is_mem_o,
  output logic       is_branch_o,
  output logic       is_illegal_o
);

  always_comb begin
    is_arith_o   = 1'b0;
    uses_imm_o   = 1'b0;
    is_mem_o     = 1'b0;
    is_branch_o  = 1'b0;
    is_illegal_o = 1'b0;
    unique case (opcode_i)
      OP_NOP, OP_HALT: ;
      OP_ADD, OP_SUB:  is_arith_o = 1'b1;
      OP_ADDI, OP_SUBI: begin
        is_arith_o = 1'b1;
        uses_imm_o = 1'b1;
      end
      OP_LW, OP_SW: begin
        is_mem_o   = 1'b1;
        uses_imm_o = 1'b1;
      end
      OP_BZ, OP_JMP:   is_branch_o = 1'b1;
      default:         is_illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute sequencer around a registered ALU with one cycle of
// latency; owns the pc, instruction register, captured zero flag and halt/illegal status.
module alu_ctrl_fsm
  import alu_ctrl_fsm_pkg::*;
#(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [15:0]     imem_rdata,
  output logic [3:0]      alu_opcode,
  output logic            alu_src_imm,
  output logic [15:0]     imm_out,
  input  logic            alu_zero,
  output logic [3:0]      rf_raddr_a,
  output logic [3:0]      rf_raddr_b,
  output logic [3:0]      rf_waddr,
  output logic            rf_we,
  output logic            rf_wsel_mem,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ready,
  output logic            zero_flag,
  output logic            halted,
  output logic            illegal
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [InstrW-1:0] ir_q, ir_d;
  logic              zero_q, zero_d;
  logic              illegal_q, illegal_d;

  logic [3:0] op;
  logic       dec_arith, dec_imm, dec_mem, dec_branch, dec_illegal;
  logic       op_is_sub;

  assign op        = ir_q[OpcodeLsb +: FieldW];
  assign op_is_sub = (op == OP_SUB) || (op == OP_SUBI);

  alu_ctrl_fsm_instr_decode u_instr_decode (
    .opcode_i     (op),
    .is_arith_o   (dec_arith),
    .uses_imm_o   (dec_imm),
    .is_mem_o     (dec_mem),
    .is_branch_o  (dec_branch),
    .is_illegal_o (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pc_q      <= PC_W'(RESET_PC);
      ir_q      <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    imem_req    = 1'b0;
    alu_opcode  = OP_NOP;
    alu_src_imm = 1'b0;
    rf_we       = 1'b0;
    rf_wsel_mem = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + PC_W'(1);
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (dec_illegal) begin
          illegal_d = 1'b1;
          state_d   = StHalt;
        end else if (op == OP_HALT) begin
          state_d = StHalt;
        end else if (op == OP_NOP) begin
          state_d = StFetch;
        end else if (dec_branch) begin
          // pc already points past the branch, so the bz offset is relative to pc + 1
          if (op == OP_JMP) begin
            pc_d = PC_W'(ir_q[JmpW-1:0]);
          end else if (zero_q) begin
            pc_d = pc_q + PC_W'($signed(sext_imm4(ir_q[RtLsb +: FieldW])));
          end
          state_d = StFetch;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        alu_opcode  = dec_mem ? OP_ADDI : op;
        alu_src_imm = dec_imm;
        state_d     = StAwait;
      end
      StAwait: begin
        // alu_zero is only meaningful in the cycle right after EXEC
        if (op_is_sub) zero_d = alu_zero;
        state_d = dec_mem ? StMem : StWb;
      end
      StWb: begin
        rf_we   = dec_arith;
        state_d = StFetch;
      end
      StMem: begin
        dmem_req    = 1'b1;
        dmem_we     = (op == OP_SW);
        rf_wsel_mem = (op == OP_LW);
        if (dmem_ready) begin
          rf_we   = (op == OP_LW);
          state_d = StFetch;
        end
      end
      StHalt: ;
      default: state_d = StIdle;
    endcase
  end

  assign imem_addr  = pc_q;
  assign imm_out    = sext_imm4(ir_q[RtLsb +: FieldW]);
  assign rf_raddr_a = ir_q[RsLsb +: FieldW];
  assign rf_raddr_b = ir_q[RtLsb +: FieldW];
  assign rf_waddr   = ir_q[RdLsb +: FieldW];
  assign zero_flag  = zero_q;
  assign halted     = (state_q == StHalt);
  assign illegal    = illegal_q;

endmodule
